vga_timing_gen: RTL

//  Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.

---
 rtl/vga_timing_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: registered counters, syncs, blank and frame pulse.
// Define VGA_FRAME_COUNT_EN to build the 16-bit frame counter; otherwise it is tied to 0.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        sync,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (HT > 1024 || VT > 1024) begin : g_bad_totals
    $error("vga_timing_gen: HT/VT exceed 10-bit counter range");
  end

  localparam logic [9:0]  H_LAST = 10'(HT - 1);
  localparam logic [9:0]  V_LAST = 10'(VT - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic       x_last;
  logic       y_last;
  logic       wrap;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hs_act;
  logic       vs_act;
  logic       blank_nxt;

  // Decode from the next counter values so the registered
  // outputs line up with DrawX/DrawY in the same cycle.
  always_comb begin
    x_last = (DrawX == H_LAST);
    y_last = (DrawY == V_LAST);
    wrap   = x_last && y_last;
    x_nxt  = x_last ? 10'd0 : DrawX + 10'd1;
    y_nxt  = DrawY;
    if (x_last) begin
      y_nxt = y_last ? 10'd0 : DrawY + 10'd1;
    end
    hs_act = ({1'b0, x_nxt} >= HS_ON) && ({1'b0, x_nxt} < HS_OFF);
    vs_act = ({1'b0, y_nxt} >= VS_ON) && ({1'b0, y_nxt} < VS_OFF);
    blank_nxt = ({1'b0, x_nxt} < H_VIS) && ({1'b0, y_nxt} < V_VIS);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b1;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= blank_nxt;
      hs          <= hs_act ? SYNC_POL : ~SYNC_POL;
      vs          <= vs_act ? SYNC_POL : ~SYNC_POL;
      frame_start <= wrap;
    end
  end

  assign sync = 1'b0;

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = 16'h0;
`endif

endmodule
